decode_cycle: RTL

- Second stage of the 5-stage RV32I pipeline. Sits directly downstream of the fetch stage.
- Consumes InstrD/PCD/PCPlus4D, decodes control, reads the register file, sign-extends immediates, and registers everything into the ID/EX pipeline register for the execute stage.
- Owns the architectural register file; the writeback stage writes it through the W-stage ports.
- Supports: lw, sw, R-type (add, sub, and, or, slt), I-type ALU (addi, andi, ori, slti), beq.

---
 rtl/decode_cycle_pkg.sv | 57 +++++
 rtl/decode_cycle_register_file.sv | 49 ++++
 rtl/decode_cycle.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/decode_cycle_pkg.sv
// Shared constants and decode helpers for the RV32I decode stage.
// Covers the subset: lw, sw, R-type ALU, I-type ALU and beq.
package decode_cycle_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctrl_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10
   } imm_src_e;

   typedef struct packed {
      logic      reg_write;
      logic      result_src;
      logic      mem_write;
      logic      branch;
      logic      alu_src;
      alu_ctrl_e alu_control;
      imm_src_e  imm_src;
   } ctrl_t;

   typedef struct packed {
      logic      valid;
      alu_ctrl_e op;
   } alu_dec_t;

   // funct7[5] selects sub only when the caller says the instruction is R-type.
   function automatic alu_dec_t alu_decode(input logic [2:0] funct3,
                                           input logic       funct7_5,
                                           input logic       is_rtype);
      alu_dec_t r;
      r.valid = 1'b1;
      r.op    = ALU_ADD;
      case (funct3)
         3'b000:  r.op = (is_rtype && funct7_5) ? ALU_SUB : ALU_ADD;
         3'b111:  r.op = ALU_AND;
         3'b110:  r.op = ALU_OR;
         3'b010:  r.op = ALU_SLT;
         default: r.valid = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/decode_cycle_register_file.sv
// Architectural register file: two async read ports, one write port,
// x0 hard-wired to zero and same-cycle write-to-read bypass.
module decode_cycle_register_file
   import decode_cycle_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [AW-1:0]   wa,
   input  logic [XLEN-1:0] wd,
   input  logic [AW-1:0]   ra1,
   input  logic [AW-1:0]   ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic [XLEN-1:0] regs_d [NREGS];
   logic            wr_en;

   assign wr_en = we && (wa != '0);

   always_comb begin
      regs_d[0] = '0;
      for (int unsigned i = 1; i < NREGS; i++) begin
         regs_d[i] = (wr_en && (wa == AW'(i))) ? wd : regs_q[i];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         regs_q <= '{default: '0};
      end else begin
         regs_q <= regs_d;
      end
   end

   always_comb begin
      rd1 = '0;
      rd2 = '0;
      if (ra1 != '0) rd1 = (wr_en && (wa == ra1)) ? wd : regs_q[ra1];
      if (ra2 != '0) rd2 = (wr_en && (wa == ra2)) ? wd : regs_q[ra2];
   end

endmodule

// File: rtl/decode_cycle.sv
// RV32I decode stage: control decode, register read, immediate extension,
// and the ID/EX pipeline register feeding execute.
module decode_cycle
   import decode_cycle_pkg::*;
#(
   parameter int unsigned XLEN  = 32,
   parameter int unsigned NREGS = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              InstrD,
   input  logic [XLEN-1:0]          PCD,
   input  logic [XLEN-1:0]          PCPlus4D,
   input  logic                     RegWriteW,
   input  logic [$clog2(NREGS)-1:0] RDW,
   input  logic [XLEN-1:0]          ResultW,
   input  logic                     FlushE,
   output logic                     RegWriteE,
   output logic                     ResultSrcE,
   output logic                     MemWriteE,
   output logic                     BranchE,
   output logic                     ALUSrcE,
   output logic [2:0]               ALUControlE,
   output logic [XLEN-1:0]          RD1E,
   output logic [XLEN-1:0]          RD2E,
   output logic [XLEN-1:0]          ImmExtE,
   output logic [$clog2(NREGS)-1:0] RS1E,
   output logic [$clog2(NREGS)-1:0] RS2E,
   output logic [$clog2(NREGS)-1:0] RDE,
   output logic [XLEN-1:0]          PCE,
   output logic [XLEN-1:0]          PCPlus4E
);

   localparam int unsigned AW = $clog2(NREGS);

   typedef struct packed {
      logic            reg_write;
      logic            result_src;
      logic            mem_write;
      logic            branch;
      logic            alu_src;
      logic [2:0]      alu_control;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm_ext;
      logic [AW-1:0]   rs1;
      logic [AW-1:0]   rs2;
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
   } id_ex_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_5;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [AW-1:0]   rd;
   logic [XLEN-1:0] rd1;
   logic [XLEN-1:0] rd2;
   logic [XLEN-1:0] imm_ext;
   ctrl_t           ctrl;
   alu_dec_t        alu_dec;
   id_ex_t          id_ex_d;
   id_ex_t          id_ex_q;

   assign opcode   = InstrD[6:0];
   assign rd       = AW'(InstrD[11:7]);
   assign funct3   = InstrD[14:12];
   assign rs1      = AW'(InstrD[19:15]);
   assign rs2      = AW'(InstrD[24:20]);
   assign funct7_5 = InstrD[30];

   decode_cycle_register_file #(
      .XLEN  (XLEN),
      .NREGS (NREGS)
   ) u_register_file (
      .clk (clk),
      .rst (rst),
      .we  (RegWriteW),
      .wa  (RDW),
      .wd  (ResultW),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   always_comb begin
      ctrl    = '0;
      alu_dec = alu_decode(funct3, funct7_5, opcode == OP_RTYPE);
      case (opcode)
         OP_LOAD: begin
            ctrl.reg_write  = 1'b1;
            ctrl.result_src = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.imm_src    = IMM_I;
            ctrl.alu_control = ALU_ADD;
         end
         OP_STORE: begin
            ctrl.mem_write   = 1'b1;
            ctrl.alu_src     = 1'b1;
            ctrl.imm_src     = IMM_S;
            ctrl.alu_control = ALU_ADD;
         end
         OP_RTYPE: begin
            if (alu_dec.valid) begin
               ctrl.reg_write   = 1'b1;
               ctrl.alu_control = alu_dec.op;
            end
         end
         OP_ITYPE: begin
            if (alu_dec.valid) begin
               ctrl.reg_write   = 1'b1;
               ctrl.alu_src     = 1'b1;
               ctrl.imm_src     = IMM_I;
               ctrl.alu_control = alu_dec.op;
            end
         end
         OP_BRANCH: begin
            ctrl.branch      = 1'b1;
            ctrl.imm_src     = IMM_B;
            ctrl.alu_control = ALU_SUB;
         end
         default: ctrl = '0;
      endcase
   end

   always_comb begin
      imm_ext = '0;
      case (ctrl.imm_src)
         IMM_S:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:25], InstrD[11:7]};
         IMM_B:   imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[7], InstrD[30:25],
                             InstrD[11:8], 1'b0};
         default: imm_ext = {{(XLEN-12){InstrD[31]}}, InstrD[31:20]};
      endcase
   end

   always_comb begin
      id_ex_d = '0;
      if (!FlushE) begin
         id_ex_d.reg_write   = ctrl.reg_write;
         id_ex_d.result_src  = ctrl.result_src;
         id_ex_d.mem_write   = ctrl.mem_write;
         id_ex_d.branch      = ctrl.branch;
         id_ex_d.alu_src     = ctrl.alu_src;
         id_ex_d.alu_control = ctrl.alu_control;
         id_ex_d.rd1         = rd1;
         id_ex_d.rd2         = rd2;
         id_ex_d.imm_ext     = imm_ext;
         id_ex_d.rs1         = rs1;
         id_ex_d.rs2         = rs2;
         id_ex_d.rd          = rd;
         id_ex_d.pc          = PCD;
         id_ex_d.pc_plus4    = PCPlus4D;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         id_ex_q <= '0;
      end else begin
         id_ex_q <= id_ex_d;
      end
   end

   assign RegWriteE   = id_ex_q.reg_write;
   assign ResultSrcE  = id_ex_q.result_src;
   assign MemWriteE   = id_ex_q.mem_write;
   assign BranchE     = id_ex_q.branch;
   assign ALUSrcE     = id_ex_q.alu_src;
   assign ALUControlE = id_ex_q.alu_control;
   assign RD1E        = id_ex_q.rd1;
   assign RD2E        = id_ex_q.rd2;
   assign ImmExtE     = id_ex_q.imm_ext;
   assign RS1E        = id_ex_q.rs1;
   assign RS2E        = id_ex_q.rs2;
   assign RDE         = id_ex_q.rd;
   assign PCE         = id_ex_q.pc;
   assign PCPlus4E    = id_ex_q.pc_plus4;

endmodule
